lane_serializer: RTL and testbench

- Consumer stage for an array of SVI lanes: sits directly downstream of the latch stage that drives `I.P1 p1[SIZE-1:0]`.
- Reads all lanes through `I.P2` modports and takes a SIZE-bit snapshot on request.
- Shifts the snapshot out LSB-first on a single-bit valid/ready stream, then pulses done.
- Gives top a registered, flow-controlled view of the latched lane vector.

---
 rtl/lane_serializer_pkg.sv | 19 +
 rtl/lane_serializer_if.sv | 7 +
 rtl/lane_serializer.sv | 123 ++++++++++++
 tb/tb_lane_serializer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lane_serializer_pkg.sv
// Shared types and helpers for the lane serializer.
// Optional feature macro: LANE_SERIALIZER_PARITY_EN (adds a trailing even-parity bit).
package lane_ser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned SIZE_DEFAULT = 8;

   // Width needed to hold a count from 0 up to and including size.
   function automatic int unsigned cnt_w(input int unsigned size);
      return $clog2(size + 1);
   endfunction

endpackage

// File: rtl/lane_serializer_if.sv
// Single-bit SVI lane: P1 is the latch-stage driver side, P2 the reader side.
interface I;
   logic y;

   modport P1 (output y);
   modport P2 (input y);
endinterface

// File: rtl/lane_serializer.sv
// Snapshots SIZE lane bits on request and shifts them out LSB-first on a
// one-bit valid/ready stream, pulsing o_done after the last transfer.
// Optional feature macro: LANE_SERIALIZER_PARITY_EN appends an even-parity bit.
module lane_serializer
   import lane_ser_pkg::*;
#(
   parameter int unsigned SIZE = SIZE_DEFAULT,
`ifdef LANE_SERIALIZER_PARITY_EN
   localparam int unsigned CntW = cnt_w(SIZE + 1)
`else
   localparam int unsigned CntW = cnt_w(SIZE)
`endif
) (
   input  logic            i_clk,
   input  logic            i_arst,
   I.P2                    p2 [SIZE-1:0],
   input  logic            i_start,
   input  logic            i_ready,
   output logic            o_valid,
   output logic            o_data,
   output logic            o_busy,
   output logic            o_done,
   output logic [CntW-1:0] o_cnt
);

   state_t            state_q;
   logic [SIZE-1:0]   shreg_q;
   logic [CntW-1:0]   cnt_q;
   logic [SIZE-1:0]   lanes;
   logic              xfer;
`ifdef LANE_SERIALIZER_PARITY_EN
   logic              par_q;
`endif

   // Gather the lane array into a packed vector for the snapshot.
   for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
      assign lanes[gi] = p2[gi].y;
   end

   assign xfer = o_valid & i_ready;

   // FSM and datapath: snapshot in IDLE, shift on each transfer, one DONE cycle.
   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
`ifdef LANE_SERIALIZER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (i_start) begin
                  shreg_q <= lanes;
`ifdef LANE_SERIALIZER_PARITY_EN
                  par_q   <= ^lanes;
`endif
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (xfer) begin
                  shreg_q <= shreg_q >> 1;
                  cnt_q   <= cnt_q + 1'b1;
                  if (cnt_q == CntW'(SIZE - 1)) begin
`ifdef LANE_SERIALIZER_PARITY_EN
                     state_q <= PAR;
`else
                     state_q <= DONE;
`endif
                  end
               end
            end
`ifdef LANE_SERIALIZER_PARITY_EN
            PAR: begin
               if (xfer) begin
                  cnt_q   <= cnt_q + 1'b1;
                  state_q <= DONE;
               end
            end
`endif
            DONE: begin
               // o_cnt keeps the final count here and clears as IDLE is entered.
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Outputs decoded from registered state only; i_ready never reaches o_valid.
   always_comb begin
      o_valid = 1'b0;
      o_data  = 1'b0;
      unique case (state_q)
         SHIFT: begin
            o_valid = 1'b1;
            o_data  = shreg_q[0];
         end
`ifdef LANE_SERIALIZER_PARITY_EN
         PAR: begin
            o_valid = 1'b1;
            o_data  = par_q;
         end
`endif
         default: begin
            o_valid = 1'b0;
            o_data  = 1'b0;
         end
      endcase
   end

   assign o_busy = (state_q != IDLE);
   assign o_done = (state_q == DONE);
   assign o_cnt  = cnt_q;

endmodule

// File: tb/tb_lane_serializer.sv
// Randomized bench for lane_serializer against a queue-based frame model.
// Honours LANE_SERIALIZER_PARITY_EN when defined for both bench and design.
module tb_lane_serializer;
   import lane_ser_pkg::*;

   localparam int unsigned SIZE = 8;
`ifdef LANE_SERIALIZER_PARITY_EN
   localparam int unsigned CntW = cnt_w(SIZE + 1);
`else
   localparam int unsigned CntW = cnt_w(SIZE);
`endif

   logic            clk;
   logic            rst_n;
   logic            start;
   logic            ready;
   logic [SIZE-1:0] lane_vec;
   logic            valid;
   logic            data;
   logic            busy;
   logic            done;
   logic [CntW-1:0] cnt;

   int n_cmp;
   int n_err;

   // Model: pending bits of the frame, busy/done flags and transfer count.
   bit m_busy;
   bit m_done;
   int m_cnt;
   bit m_bits[$];

   I lanes_if [SIZE-1:0] ();

   for (genvar g = 0; g < SIZE; g++) begin : g_drv
      assign lanes_if[g].y = lane_vec[g];
   end

   lane_serializer #(.SIZE(SIZE)) dut (
      .i_clk   (clk),
      .i_arst  (rst_n),
      .p2      (lanes_if),
      .i_start (start),
      .i_ready (ready),
      .o_valid (valid),
      .o_data  (data),
      .o_busy  (busy),
      .o_done  (done),
      .o_cnt   (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      bit exp_valid;
      exp_valid = (m_bits.size() > 0);
      check_eq("valid", 32'(valid), 32'(exp_valid));
      check_eq("data", 32'(data), exp_valid ? 32'(m_bits[0]) : 32'd0);
      check_eq("busy", 32'(busy), 32'(m_busy));
      check_eq("done", 32'(done), 32'(m_done));
      check_eq("cnt", 32'(cnt), 32'(m_cnt));
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
      m_bits.delete();
   endtask

   // Advance the model across one rising edge with the given inputs.
   task automatic model_edge(input bit st, input bit rdy, input logic [SIZE-1:0] ln);
      if (m_done) begin
         m_done = 1'b0;
         m_busy = 1'b0;
         m_cnt  = 0;
      end else if (!m_busy) begin
         if (st) begin
            for (int i = 0; i < SIZE; i++) m_bits.push_back(ln[i]);
`ifdef LANE_SERIALIZER_PARITY_EN
            m_bits.push_back(^ln);
`endif
            m_busy = 1'b1;
            m_cnt  = 0;
         end
      end else if (rdy) begin
         void'(m_bits.pop_front());
         m_cnt++;
         if (m_bits.size() == 0) m_done = 1'b1;
      end
   endtask

   // One cycle: check at the falling edge, then apply inputs for the next rising edge.
   task automatic step(input bit st, input bit rdy, input logic [SIZE-1:0] ln);
      @(negedge clk);
      check_outputs();
      start    = st;
      ready    = rdy;
      lane_vec = ln;
      model_edge(st, rdy, ln);
   endtask

   // Assert reset between edges, expect outputs to clear at once, release later.
   task automatic pulse_reset();
      @(posedge clk);
      #1;
      check_outputs();
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_data", 32'(data), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_cnt", 32'(cnt), 32'd0);
      model_reset();
      start = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      ready    = 1'b0;
      lane_vec = '0;
      model_reset();
      #1;
      check_eq("por_valid", 32'(valid), 32'd0);
      check_eq("por_busy", 32'(busy), 32'd0);
      check_eq("por_done", 32'(done), 32'd0);
      check_eq("por_cnt", 32'(cnt), 32'd0);
      #11;
      rst_n = 1'b1;

      // Plain frame, always ready.
      step(1'b1, 1'b1, 8'hA5);
      repeat (11) step(1'b0, 1'b1, 8'hA5);

      // Alternating ready stalls.
      step(1'b1, 1'b1, 8'h3C);
      for (int i = 0; i < 24; i++) step(1'b0, (i % 2) == 0, 8'h3C);

      // Start held high throughout: back-to-back frames with DONE start ignored.
      for (int i = 0; i < 3 * (SIZE + 4); i++) step(1'b1, 1'b1, 8'h5A ^ 8'(i));
      for (int i = 0; i < SIZE + 4; i++) step(1'b0, 1'b1, 8'h00);

      // Lanes drop right after the snapshot edge.
      step(1'b1, 1'b1, 8'hFF);
      repeat (SIZE + 3) step(1'b0, 1'b1, 8'h00);

      // Reset after three transfers, then a fresh frame.
      step(1'b1, 1'b1, 8'hC3);
      repeat (3) step(1'b0, 1'b1, 8'hC3);
      pulse_reset();
      step(1'b1, 1'b1, 8'h96);
      repeat (SIZE + 3) step(1'b0, 1'b1, 8'h96);

`ifdef LANE_SERIALIZER_PARITY_EN
      step(1'b1, 1'b1, 8'h07);
      repeat (SIZE + 4) step(1'b0, 1'b1, 8'h07);
`endif

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            pulse_reset();
         end else begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, SIZE'($urandom));
         end
      end

      step(1'b0, 1'b1, '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
